// File: rtl/router_pkg.sv
// router_pkt_tx shared types, constants and header packing.
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PLD,
    S_PAR,
    S_GAP
  } state_e;

  localparam int MAX_PLD_LEN = 63;
  localparam int LEN_W = $clog2(MAX_PLD_LEN + 1);
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  function automatic logic [7:0] pack_hdr(
    input logic [LEN_W-1:0] len,
    input logic [1:0]       addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// User request, payload source and router port of router_pkt_tx.
interface router_pkt_tx_if;

  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pld_len;
  logic       inject_perr;
  logic [7:0] pld_data;
  logic [6:0] pld_count;
  logic       pld_rd;
  logic       busy;
  logic       error;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic       err_seen;
  logic       req_rej;

  modport master (
    output start, dest_addr, pld_len, inject_perr,
    output pld_data, pld_count, busy, error,
    input  pld_rd, data_out, pkt_valid,
    input  tx_active, done, err_seen, req_rej
  );

  modport slave (
    input  start, dest_addr, pld_len, inject_perr,
    input  pld_data, pld_count, busy, error,
    output pld_rd, data_out, pkt_valid,
    output tx_active, done, err_seen, req_rej
  );

endinterface

// File: rtl/router_parity_acc.sv
// 8-bit XOR accumulator: load seeds, xor_en folds data_i,
// inv_i flips the presented result.
module router_parity_acc (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       xor_en_i,
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] parity_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= load_val_i;
    end else if (xor_en_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign parity_o = acc_q ^ {8{inv_i}};

endmodule

// File: rtl/router_pkt_tx.sv
// Serialises header, payload and parity into the router port,
// then watches router error through a fixed post-packet gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 3
) (
  input logic       clock,
  input logic       resetn,
  router_pkt_tx_if.slave bus
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e           state_q;
  logic [7:0]       dout_q;
  logic             pv_q;
  logic             act_q;
  logic             done_q;
  logic             errs_q;
  logic             rej_q;
  logic             perr_q;
  logic [LEN_W-1:0] rem_q;
  logic [CW-1:0]    gap_q;

  logic       take;
  logic       go;
  logic       par_ld;
  logic       pld_rd;
  logic [7:0] hdr;
  logic [7:0] par;

  assign take = !bus.busy;
  assign hdr  = pack_hdr(bus.pld_len, bus.dest_addr);

  assign go = bus.start
           && (bus.dest_addr != ADDR_ILLEGAL)
           && (bus.pld_len != '0)
           && (bus.pld_count >= {1'b0, bus.pld_len});

  assign par_ld = (state_q == S_IDLE) && go;

  // rem==0 in PLD means the last byte is already on the wire
  assign pld_rd = take
               && ((state_q == S_HDR)
               || ((state_q == S_PLD) && (rem_q != '0)));

  router_parity_acc u_par (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .load_i     (par_ld),
    .load_val_i (hdr),
    .xor_en_i   (pld_rd),
    .data_i     (bus.pld_data),
    .inv_i      (perr_q),
    .parity_o   (par)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      pv_q    <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      errs_q  <= 1'b0;
      rej_q   <= 1'b0;
      perr_q  <= 1'b0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            dout_q  <= hdr;
            pv_q    <= 1'b1;
            act_q   <= 1'b1;
            rem_q   <= bus.pld_len;
            perr_q  <= bus.inject_perr;
            state_q <= S_HDR;
          end else if (bus.start) begin
            rej_q <= 1'b1;
          end
        end
        S_HDR: begin
          if (take) begin
            dout_q  <= bus.pld_data;
            rem_q   <= rem_q - LEN_W'(1);
            state_q <= S_PLD;
          end
        end
        S_PLD: begin
          if (take) begin
            if (rem_q != '0) begin
              dout_q <= bus.pld_data;
              rem_q  <= rem_q - LEN_W'(1);
            end else begin
              dout_q  <= par;
              pv_q    <= 1'b0;
              state_q <= S_PAR;
            end
          end
        end
        S_PAR: begin
          if (take) begin
            dout_q  <= '0;
            gap_q   <= CW'(GAP_CYCLES - 1);
            errs_q  <= 1'b0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          errs_q <= errs_q | bus.error;
          if (gap_q == '0) begin
            done_q  <= 1'b1;
            act_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pld_rd    = pld_rd;
  assign bus.data_out  = dout_q;
  assign bus.pkt_valid = pv_q;
  assign bus.tx_active = act_q;
  assign bus.done      = done_q;
  assign bus.err_seen  = errs_q;
  assign bus.req_rej   = rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: payload FIFO, router model with
// parity check, directed table plus random packets.
module tb_router_pkt_tx;

  localparam int G = 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.GAP_CYCLES(G)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    int          addr;
    int          len;
    bit          perr;
    int          avail;
    byte unsigned base;
    byte unsigned step;
    int          bm;
    bit          exp_rej;
    logic [7:0]  exp_par;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  byte unsigned src_q[$];
  logic [8:0]   exp_q[$];

  int bmode = 0;
  int stall_cnt = 0;
  bit stall_done = 0;
  int err_hold = 0;

  bit         in_pkt = 0;
  logic [7:0] rx_par = 0;
  int         cur_len = 0;

  int rd_cnt, pv_cnt, rd_busy, hold_cnt;
  int hdr_cnt, rej_cnt, done_cnt;
  int hdr_cyc, par_cyc, done_cyc;
  bit s_rej, s_pv, s_act, s_errs, s_act_done;
  logic [7:0] s_par;
  logic [7:0] par_seen[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, observe at negedge.
  task automatic tick();
    bit rd;
    bus.pld_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    bus.pld_count = (src_q.size() > 127) ? 7'd127 : 7'(src_q.size());
    case (bmode)
      1: begin
        if (stall_cnt > 0) begin
          bus.busy = 1'b1;
          stall_cnt--;
        end else if (!stall_done && bus.pkt_valid && cur_len == 2) begin
          bus.busy = 1'b1;
          stall_cnt = 2;
          stall_done = 1;
        end else begin
          bus.busy = 1'b0;
        end
      end
      2: bus.busy = ($urandom_range(0, 3) == 0);
      default: bus.busy = 1'b0;
    endcase
    bus.error = (err_hold > 0);
    @(negedge clock);
    rd    = bus.pld_rd;
    s_rej = bus.req_rej;
    s_pv  = bus.pkt_valid;
    s_act = bus.tx_active;
    if (bus.req_rej) rej_cnt++;
    if (rd) rd_cnt++;
    if (rd && bus.busy) rd_busy++;
    if (bus.pkt_valid && cur_len == 2) hold_cnt++;
    if (!bus.busy && (bus.pkt_valid || in_pkt)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got 0x%0h want none", bus.data_out);
      end else begin
        chk("stream", int'({bus.pkt_valid, bus.data_out}),
            int'(exp_q.pop_front()));
      end
      if (bus.pkt_valid) begin
        if (!in_pkt) begin
          hdr_cyc = cyc;
          hdr_cnt++;
        end
        in_pkt = 1;
        cur_len++;
        rx_par = rx_par ^ bus.data_out;
        pv_cnt++;
      end else begin
        in_pkt = 0;
        par_cyc = cyc;
        s_par = bus.data_out;
        par_seen.push_back(bus.data_out);
        if (bus.data_out != rx_par) begin
          bus.error = 1'b1;
          err_hold = 2;
        end
        rx_par = 0;
        cur_len = 0;
      end
    end
    if (bus.done) begin
      done_cyc = cyc;
      done_cnt++;
      s_errs = bus.err_seen;
      s_act_done = bus.tx_active;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (rd && src_q.size() > 0) void'(src_q.pop_front());
    if (err_hold > 0) err_hold--;
  endtask

  task automatic model_pkt(input int addr, input int len, input bit perr,
                           input int off, output logic [7:0] par);
    logic [7:0] h;
    h = 8'(len * 4 + addr);
    par = h;
    exp_q.push_back({1'b1, h});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b1, src_q[off + i]});
      par = par ^ src_q[off + i];
    end
    if (perr) par = ~par;
    exp_q.push_back({1'b0, par});
  endtask

  task automatic clr_stats(input int bm);
    bmode = bm;
    stall_cnt = 0;
    stall_done = 0;
    rd_cnt = 0;
    pv_cnt = 0;
    rd_busy = 0;
    hold_cnt = 0;
    hdr_cnt = 0;
    rej_cnt = 0;
    done_cnt = 0;
    hdr_cyc = -1;
    par_cyc = -1;
    done_cyc = -1;
    s_errs = 0;
    s_act_done = 0;
    par_seen.delete();
  endtask

  task automatic run_pkt(input int addr, input int len, input bit perr,
                         input int avail, input byte unsigned base,
                         input byte unsigned step, input bit rnd,
                         input int bm, output bit rej,
                         output logic [7:0] par);
    int n;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < avail; i++) begin
      if (rnd) src_q.push_back(8'($urandom));
      else src_q.push_back(8'(int'(base) + int'(step) * i));
    end
    rej = (addr == 3) || (len == 0) || (avail < len);
    par = 8'h00;
    if (!rej) model_pkt(addr, len, perr, 0, par);
    clr_stats(bm);
    bus.dest_addr = 2'(addr);
    bus.pld_len = 6'(len);
    bus.inject_perr = perr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("req_rej", int'(s_rej), int'(rej));
    chk("hdr_valid", int'(s_pv), int'(!rej));
    chk("tx_active", int'(s_act), int'(!rej));
    if (rej) begin
      repeat (4) tick();
      chk("rej_no_valid", pv_cnt, 0);
      chk("rej_no_rd", rd_cnt, 0);
    end else begin
      n = 0;
      while (done_cyc < 0 && n < 800) begin
        tick();
        n++;
      end
      if (done_cyc < 0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got none want done");
      end
      chk("err_seen", int'(s_errs), int'(perr));
      chk("active_at_done", int'(s_act_done), 0);
      chk("pld_rd_count", rd_cnt, len);
      chk("pv_count", pv_cnt, len + 1);
      chk("rd_while_busy", rd_busy, 0);
      chk("stream_left", exp_q.size(), 0);
      if (bm == 0) begin
        chk("data_span", par_cyc - hdr_cyc + 1, len + 2);
        chk("done_lat", done_cyc - par_cyc, G + 1);
      end
    end
  endtask

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rej;
    logic [7:0] par;
    logic [7:0] p1;
    logic [7:0] p2;
    int h1;
    int n;

    vt[0] = '{1, 4, 0, 4, 8'h11, 8'h11, 0, 0, 8'h55};
    vt[1] = '{1, 4, 0, 4, 8'h11, 8'h11, 1, 0, 8'h55};
    vt[2] = '{3, 4, 0, 4, 8'h11, 8'h11, 0, 1, 8'h00};
    vt[3] = '{0, 0, 0, 4, 8'h11, 8'h11, 0, 1, 8'h00};
    vt[4] = '{1, 5, 0, 2, 8'h11, 8'h11, 0, 1, 8'h00};
    vt[5] = '{0, 1, 1, 1, 8'h00, 8'h00, 0, 0, 8'hFB};
    vt[6] = '{2, 63, 0, 63, 8'h00, 8'h01, 0, 0, 8'hC1};
    vt[7] = '{2, 3, 0, 5, 8'hA0, 8'h01, 0, 0, 8'hAD};

    bus.start = 0;
    bus.dest_addr = 0;
    bus.pld_len = 0;
    bus.inject_perr = 0;
    bus.pld_data = 0;
    bus.pld_count = 0;
    bus.busy = 0;
    bus.error = 0;

    @(negedge clock);
    chk("reset_outs",
        int'({bus.data_out, bus.pkt_valid, bus.pld_rd, bus.tx_active,
              bus.done, bus.err_seen, bus.req_rej}), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_pkt(vt[i].addr, vt[i].len, vt[i].perr, vt[i].avail,
              vt[i].base, vt[i].step, 0, vt[i].bm, rej, par);
      if (!vt[i].exp_rej) begin
        chk("tbl_parity", int'(s_par), int'(vt[i].exp_par));
      end
      if (vt[i].bm == 1) chk("stall_hold", hold_cnt, 4);
    end

    // Reset in the cycle after the third payload byte is taken
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h30 + i));
    model_pkt(1, 5, 0, 0, par);
    clr_stats(0);
    bus.dest_addr = 2'd1;
    bus.pld_len = 6'd5;
    bus.inject_perr = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (cur_len < 4 && n < 50) begin
      tick();
      n++;
    end
    chk("pre_reset_bytes", cur_len, 4);
    resetn = 1'b0;
    #1;
    chk("midpkt_reset_outs",
        int'({bus.data_out, bus.pkt_valid, bus.pld_rd, bus.tx_active,
              bus.done, bus.err_seen, bus.req_rej}), 0);
    @(negedge clock);
    resetn = 1'b1;
    in_pkt = 0;
    cur_len = 0;
    rx_par = 0;
    err_hold = 0;
    exp_q.delete();
    src_q.delete();
    @(posedge clock);
    #1;
    run_pkt(2, 6, 0, 6, 8'h00, 8'h00, 1, 0, rej, par);
    chk("post_reset_parity", int'(s_par), int'(par));

    // Back-to-back 63-byte packets with start held high
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 126; i++) src_q.push_back(8'($urandom));
    model_pkt(0, 63, 0, 0, p1);
    model_pkt(2, 63, 0, 63, p2);
    clr_stats(0);
    bus.dest_addr = 2'd0;
    bus.pld_len = 6'd63;
    bus.inject_perr = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.dest_addr = 2'd2;
    tick();
    h1 = hdr_cyc;
    n = 0;
    while (hdr_cnt < 2 && n < 400) begin
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("b2b_period", hdr_cyc - h1, 63 + 3 + G);
    n = 0;
    while (done_cnt < 2 && n < 400) begin
      tick();
      n++;
    end
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_no_rej", rej_cnt, 0);
    chk("b2b_par_cnt", par_seen.size(), 2);
    if (par_seen.size() == 2) begin
      chk("b2b_parity1", int'(par_seen[0]), int'(p1));
      chk("b2b_parity2", int'(par_seen[1]), int'(p2));
    end
    chk("b2b_stream_left", exp_q.size(), 0);

    // Random requests with random back-pressure
    for (int k = 0; k < 25; k++) begin
      int a;
      int l;
      int av;
      a = $urandom_range(0, 3);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      if ($urandom_range(0, 4) == 0 && l > 0) av = l - 1;
      else av = l + $urandom_range(0, 2);
      run_pkt(a, l, 1'($urandom_range(0, 1)), av, 8'h00, 8'h00,
              1, 2, rej, par);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
